// File: rtl/drum_voice_player.sv
// Single-voice drum synthesiser: renders one decaying square-tone or LFSR-noise hit,
// one sample per codec tick, under a level request / done handshake.
module drum_voice_player #(
    parameter int SAMPLEWIDTH    = 16,
    parameter int KICKHALFPERIOD = 120,
    parameter int TOMHALFPERIOD  = 60,
    parameter int KICKDECAY      = 16,
    parameter int SNAREDECAY     = 8,
    parameter int HIHATDECAY     = 2,
    parameter int TOMDECAY       = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   playDrumNote,
    input  logic [2:0]             drumSelect,
    input  logic                   sampleTick,
    output logic                   donePlayingDrumNote,
    output logic [SAMPLEWIDTH-1:0] audioOut,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [15:0] TONE_AMP  = 16'sd8192;
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;

    state_t                 state, state_n;
    logic [7:0]             amp, amp_n;
    logic [7:0]             step_cnt, step_n;
    logic [11:0]            phase_cnt, phase_n;
    logic                   tone_level, tone_n;
    logic [15:0]            lfsr, lfsr_n;
    logic [1:0]             drum, drum_n;
    logic                   done_q, done_n;
    logic [SAMPLEWIDTH-1:0] audio_q, audio_n;
    logic signed [15:0]     raw;
    logic [11:0]            half_m1;

    // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [7:0] decay_m1(input logic [1:0] d);
        logic [7:0] r;
        case (d)
            2'd0:    r = 8'(KICKDECAY - 1);
            2'd1:    r = 8'(SNAREDECAY - 1);
            2'd2:    r = 8'(HIHATDECAY - 1);
            default: r = 8'(TOMDECAY - 1);
        endcase
        return r;
    endfunction

    // Envelope gain: full-width product, arithmetic >>> 8, then fit to the output width.
    function automatic logic [SAMPLEWIDTH-1:0] scale_sample(input logic signed [15:0] r,
                                                            input logic [7:0] a);
        logic signed [24:0] prod;
        logic signed [15:0] trunc;
        prod  = r * $signed({1'b0, a});
        trunc = 16'(prod >>> 8);
        return SAMPLEWIDTH'(trunc);
    endfunction

    always_comb begin
        half_m1 = (drum == 2'd0) ? 12'(KICKHALFPERIOD - 1) : 12'(TOMHALFPERIOD - 1);
        case (drum)
            2'd1:    raw = $signed(lfsr) >>> 2;
            2'd2:    raw = $signed(lfsr) >>> 3;
            default: raw = tone_level ? TONE_AMP : -TONE_AMP;
        endcase
    end

    always_comb begin
        state_n = state;
        amp_n   = amp;
        step_n  = step_cnt;
        phase_n = phase_cnt;
        tone_n  = tone_level;
        drum_n  = drum;
        done_n  = done_q;
        audio_n = audio_q;
        lfsr_n  = sampleTick ? lfsr_advance(lfsr) : lfsr;

        case (state)
            IDLE: begin
                if (playDrumNote) begin
                    if (!drumSelect[2]) begin
                        drum_n  = drumSelect[1:0];
                        amp_n   = 8'hFF;
                        step_n  = decay_m1(drumSelect[1:0]);
                        phase_n = '0;
                        tone_n  = 1'b1;
                        state_n = PLAY;
                    end else begin
                        audio_n = '0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            PLAY: begin
                if (!playDrumNote) begin
                    audio_n = '0;
                    state_n = IDLE;
                end else if (sampleTick) begin
                    audio_n = scale_sample(raw, amp);
                    if (phase_cnt == half_m1) begin
                        phase_n = '0;
                        tone_n  = ~tone_level;
                    end else begin
                        phase_n = phase_cnt + 12'd1;
                    end
                    if (step_cnt == 8'd0) begin
                        step_n = decay_m1(drum);
                        amp_n  = amp - 8'd1;
                        // Last envelope step expires: the hit ends on this tick.
                        if (amp == 8'd1) begin
                            audio_n = '0;
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    end else begin
                        step_n = step_cnt - 8'd1;
                    end
                end
            end
            DONE: begin
                audio_n = '0;
                done_n  = 1'b1;
                if (!playDrumNote) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            amp        <= 8'hFF;
            step_cnt   <= '0;
            phase_cnt  <= '0;
            tone_level <= 1'b1;
            lfsr       <= LFSR_SEED;
            drum       <= '0;
            done_q     <= 1'b0;
            audio_q    <= '0;
        end else begin
            state      <= state_n;
            amp        <= amp_n;
            step_cnt   <= step_n;
            phase_cnt  <= phase_n;
            tone_level <= tone_n;
            lfsr       <= lfsr_n;
            drum       <= drum_n;
            done_q     <= done_n;
            audio_q    <= audio_n;
        end
    end

    assign donePlayingDrumNote = done_q;
    assign audioOut            = audio_q;
    assign busy                = (state == PLAY);

endmodule

// File: tb/tb_drum_voice_player.sv
// Bench for drum_voice_player: closed-form hit model (tick index -> envelope and waveform)
// compared every cycle, plus literal expectations for key samples and handshake timing.
module tb_drum_voice_player;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        playDrumNote = 1'b0;
    logic [2:0]  drumSelect = 3'd0;
    logic        sampleTick = 1'b0;
    logic        donePlayingDrumNote;
    logic [15:0] audioOut;
    logic        busy;

    drum_voice_player dut (
        .clk                 (clk),
        .reset               (reset),
        .playDrumNote        (playDrumNote),
        .drumSelect          (drumSelect),
        .sampleTick          (sampleTick),
        .donePlayingDrumNote (donePlayingDrumNote),
        .audioOut            (audioOut),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_mode    = 0;   // 0 idle, 1 playing, 2 finished
    int m_drum    = 0;
    int m_n       = 0;   // ticks consumed in current hit
    int m_lfsr    = 'hACE1;
    int exp_audio = 0;
    int exp_done  = 0;

    function automatic int decay_of(input int d);
        case (d)
            0:       return 16;
            1:       return 8;
            2:       return 2;
            default: return 12;
        endcase
    endfunction

    function automatic int next_lfsr(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int sample_at(input int d, input int n, input int lf);
        int amp, half, raw, s;
        amp = 255 - n / decay_of(d);
        if (d == 0 || d == 3) begin
            half = (d == 0) ? 120 : 60;
            raw  = (((n / half) % 2) == 0) ? 8192 : -8192;
        end else begin
            s   = (lf >= 32768) ? lf - 65536 : lf;
            raw = (d == 1) ? (s >>> 2) : (s >>> 3);
        end
        return (raw * amp) >>> 8;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_n = 0; m_lfsr = 'hACE1; exp_audio = 0; exp_done = 0;
        end else begin
            case (m_mode)
                0: if (playDrumNote) begin
                    if (drumSelect < 3'd4) begin
                        m_mode = 1; m_drum = int'(drumSelect); m_n = 0;
                    end else begin
                        m_mode = 2; exp_done = 1; exp_audio = 0;
                    end
                end
                1: if (!playDrumNote) begin
                    m_mode = 0; exp_audio = 0;
                end else if (sampleTick) begin
                    if (m_n == 255 * decay_of(m_drum) - 1) begin
                        exp_audio = 0; m_mode = 2; exp_done = 1;
                    end else begin
                        exp_audio = sample_at(m_drum, m_n, m_lfsr);
                    end
                    m_n++;
                end
                default: if (!playDrumNote) begin
                    m_mode = 0; exp_done = 0;
                end
            endcase
            if (sampleTick) m_lfsr = next_lfsr(m_lfsr);
        end
    end

    always @(negedge clk) begin
        check("audio", int'($signed(audioOut)), exp_audio);
        check("done", int'(donePlayingDrumNote), exp_done);
        check("busy", int'(busy), int'(m_mode == 1));
    end

    // ---------------- stimulus ----------------
    int samp_q[$];

    task automatic play_hit(input logic [2:0] sel, input int gap_lo, input int gap_hi,
                            input int abort_after, output int ticks, output bit saw_done);
        samp_q.delete();
        @(negedge clk);
        playDrumNote = 1'b1;
        drumSelect   = sel;
        ticks = 0;
        saw_done = 1'b0;
        while (!saw_done && ticks < 6000 && (abort_after == 0 || ticks < abort_after)) begin
            @(negedge clk); sampleTick = 1'b1;
            @(negedge clk); sampleTick = 1'b0;
            ticks++;
            samp_q.push_back(int'($signed(audioOut)));
            saw_done = donePlayingDrumNote;
            if (!saw_done) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
        end
    endtask

    task automatic drop_play();
        @(negedge clk); playDrumNote = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  t;
        bit  d;
        int  ab;
        logic [2:0] sel;

        repeat (3) @(negedge clk);
        check("reset_audio", int'($signed(audioOut)), 0);
        check("reset_done", int'(donePlayingDrumNote), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b1;

        // Hi-hat straight after reset: LFSR starts from the seed.
        play_hit(3'd2, 0, 3, 0, t, d);
        check("hihat_len", t, 510);
        check("hihat_first", samp_q[0], -2650);
        check("hihat_last", samp_q[samp_q.size()-1], 0);
        drop_play();
        check("hihat_done_drop", int'(donePlayingDrumNote), 0);

        // Kick, tick every 4 clk.
        play_hit(3'd0, 3, 3, 0, t, d);
        check("kick_len", t, 4080);
        check("kick_first", samp_q[0], 8160);
        check("kick_pre_toggle", samp_q[119], 7936);
        check("kick_post_toggle", samp_q[120], -7936);
        drop_play();
        check("kick_done_drop", int'(donePlayingDrumNote), 0);

        // End marker: no sound, immediate done.
        @(negedge clk); playDrumNote = 1'b1; drumSelect = 3'd4;
        @(negedge clk);
        check("end_busy1", int'(busy), 0);
        check("end_done1", int'(donePlayingDrumNote), 1);
        @(negedge clk);
        check("end_busy2", int'(busy), 0);
        check("end_audio", int'($signed(audioOut)), 0);
        drop_play();

        // Snare aborted at tick 100, then a clean tom.
        play_hit(3'd1, 0, 2, 100, t, d);
        check("snare_ticks", t, 100);
        check("snare_no_done", int'(d), 0);
        drop_play();
        check("abort_busy", int'(busy), 0);
        check("abort_audio", int'($signed(audioOut)), 0);
        check("abort_done", int'(donePlayingDrumNote), 0);
        play_hit(3'd3, 0, 1, 0, t, d);
        check("tom_len", t, 3060);
        check("tom_first", samp_q[0], 8160);

        // Hold request after done: no retrigger.
        repeat (50) begin
            @(negedge clk);
            check("hold_done", int'(donePlayingDrumNote), 1);
        end
        drop_play();
        check("hold_done_drop", int'(donePlayingDrumNote), 0);

        // Random hits, some aborted.
        for (int k = 0; k < 3; k++) begin
            sel = 3'($urandom_range(0, 7));
            ab  = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 300));
            play_hit(sel, 0, 1, ab, t, d);
            if (ab == 0 && sel < 3'd4) check("rand_len", t, 255 * decay_of(int'(sel)));
            drop_play();
            @(negedge clk);
        end

        // Async reset mid-kick at amp 200.
        play_hit(3'd0, 0, 0, 880, t, d);
        #3 reset = 1'b0;
        #1;
        check("rst_audio", int'($signed(audioOut)), 0);
        check("rst_done", int'(donePlayingDrumNote), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk); playDrumNote = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        playDrumNote = 1'b1; drumSelect = 3'd0;
        @(negedge clk);
        check("start_latency", int'(busy), 1);
        drop_play();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
